// File: rtl/seg7_reader_if.sv
// seg7_reader_if: output slot bundle of the 7-segment reader.
//   digit_out   [3:0] decoded digit 0..9, or 4'hF for an invalid pattern
//   invalid           digit_out came from an illegal segment pattern
//   digit_valid       slot holds data
//   digit_ready       consumer accepts the slot when digit_valid && digit_ready
// master = the reader (producer), slave = the consumer.
interface seg7_reader_if;
   logic [3:0] digit_out;
   logic       invalid;
   logic       digit_valid;
   logic       digit_ready;

   modport master (
      output digit_out,
      output invalid,
      output digit_valid,
      input  digit_ready
   );

   modport slave (
      input  digit_out,
      input  invalid,
      input  digit_valid,
      output digit_ready
   );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: samples a 7-segment pattern {g,f,e,d,c,b,a} from the pins, waits
// until it has been stable for STABLE_CYCLES samples, decodes it back to a BCD
// digit and offers each newly settled digit through a one-deep valid/ready slot.
//
// Ports:
//   clk        clock
//   rst_n      synchronous reset, active low
//   ena        block enable; low freezes detection (slot handshake still works)
//   seg_in     [6:0] segment pattern, active high, bit0 = a
//   dout       seg7_reader_if.master: digit_out, invalid, digit_valid, digit_ready
//   err_count  [7:0] saturating count of emitted invalid patterns
//
// Build option: define SEG7_READER_ERRCNT_EN to build the invalid-pattern
// counter; otherwise err_count is tied to zero.
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [6:0]          seg_in,
   seg7_reader_if.master       dout,
   output logic [7:0]          err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       samp_q, samp_d;
   logic [6:0]       prev_q, prev_d;
   logic [6:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       digit_q, digit_d;
   logic             inv_q, inv_d;
   logic             valid_q, valid_d;

   logic             same;
   logic             settled;
   logic             slot_free;
   logic             emit;
   logic [3:0]       dec_digit;
   logic             dec_inv;

   // segments -> digit
   always_comb begin
      dec_digit = 4'hF;
      dec_inv   = 1'b0;
      case (samp_q)
         7'b0111111: dec_digit = 4'd0;
         7'b0000110: dec_digit = 4'd1;
         7'b1011011: dec_digit = 4'd2;
         7'b1001111: dec_digit = 4'd3;
         7'b1100110: dec_digit = 4'd4;
         7'b1101101: dec_digit = 4'd5;
         7'b1111101: dec_digit = 4'd6;
         7'b0000111: dec_digit = 4'd7;
         7'b1111111: dec_digit = 4'd8;
         7'b1101111: dec_digit = 4'd9;
         default: begin
            dec_digit = 4'hF;
            dec_inv   = 1'b1;
         end
      endcase
   end

   // sample pipeline, stability counter and state
   always_comb begin
      samp_d  = samp_q;
      prev_d  = prev_q;
      cnt_d   = '0;
      state_d = state_q;
      same    = (samp_q == prev_q);

      if (ena) begin
         samp_d = seg_in;
         prev_d = samp_q;
         if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         end
      end

      if (!ena) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SETTLE;
            // lock on the edge the count reaches its end value so the first
            // LOCKED cycle can already emit
            SETTLE:  if (same && cnt_d == CNT_MAX) state_d = LOCKED;
            LOCKED:  if (!same) state_d = SETTLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // emit decision and output slot
   always_comb begin
      settled   = ena && (state_q == LOCKED) && same;
      slot_free = !valid_q || dout.digit_ready;
      emit      = settled && (samp_q != '0) && (samp_q != last_q) && slot_free;

      last_d  = last_q;
      digit_d = digit_q;
      inv_d   = inv_q;
      valid_d = valid_q;

      if (emit) begin
         last_d  = samp_q;
         digit_d = dec_digit;
         inv_d   = dec_inv;
         valid_d = 1'b1;
      end else begin
         // a settled blank forgets the last digit so it can be shown again
         if (settled && samp_q == '0) last_d = '0;
         if (valid_q && dout.digit_ready) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         samp_q  <= '0;
         prev_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         digit_q <= '0;
         inv_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         samp_q  <= samp_d;
         prev_q  <= prev_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         inv_q   <= inv_d;
         valid_q <= valid_d;
      end
   end

   assign dout.digit_out   = digit_q;
   assign dout.invalid     = inv_q;
   assign dout.digit_valid = valid_q;

`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (emit && dec_inv && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed test of seg7_reader with STABLE_CYCLES = 4.
// Accepted slot contents are logged as {invalid, digit_out} and compared
// against hand-computed expectations.
module tb_seg7_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [6:0] seg_in;
   logic [7:0] err_count;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   logic [4:0] acc_q[$];

   seg7_reader_if u_if ();

   seg7_reader #(
      .STABLE_CYCLES(4),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .seg_in(seg_in),
      .dout(u_if),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // log every handshake
   always @(negedge clk) begin
      if (rst_n && u_if.digit_valid && u_if.digit_ready)
         acc_q.push_back({u_if.invalid, u_if.digit_out});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      seg_in = p;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [4:0] acc_at(input int i);
      if (i < acc_q.size()) return acc_q[i];
      return 5'h00;
   endfunction

   localparam logic [6:0] S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111,
                          S4 = 7'b1100110, S5 = 7'b1101101, S7 = 7'b0000111,
                          S8 = 7'b1111111, S9 = 7'b1101111, SBAD = 7'b1010101,
                          SGL = 7'b1111110, SBLK = 7'b0000000;

`ifdef SEG7_READER_ERRCNT_EN
   localparam logic [7:0] ERR_ONE = 8'd1, ERR_SAT = 8'd255;
`else
   localparam logic [7:0] ERR_ONE = 8'd0, ERR_SAT = 8'd0;
`endif

   initial begin
      int first_k;
      int nval;

      // reset
      rst_n = 1'b0;
      ena = 1'b1;
      seg_in = '0;
      u_if.digit_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(u_if.digit_valid), 32'd0);
      chk("rst_digit", 32'(u_if.digit_out), 32'd0);
      chk("rst_inv", 32'(u_if.invalid), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);

      // 3 held 10 cycles: single pulse after edge 6
      rst_n = 1'b1;
      seg_in = S3;
      first_k = 0;
      nval = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (u_if.digit_valid) begin
            nval++;
            if (first_k == 0) first_k = k;
         end
      end
      chk("t1_first_edge", 32'(first_k), 32'd6);
      chk("t1_pulses", 32'(nval), 32'd1);
      chk("t1_n", 32'(acc_q.size()), 32'd1);
      chk("t1_val", 32'(acc_at(0)), 32'h03);

      // 1 too short to settle, then 2
      acc_q.delete();
      hold(S1, 3);
      hold(S2, 10);
      chk("t2_n", 32'(acc_q.size()), 32'd1);
      chk("t2_val", 32'(acc_at(0)), 32'h02);

      // backpressure: 5 held in slot, 7 lost, 4 emitted
      acc_q.delete();
      u_if.digit_ready = 1'b0;
      hold(S5, 8);
      chk("t3_valid5", 32'(u_if.digit_valid), 32'd1);
      chk("t3_dig5a", 32'(u_if.digit_out), 32'd5);
      hold(S7, 8);
      chk("t3_dig5b", 32'(u_if.digit_out), 32'd5);
      hold(S4, 8);
      chk("t3_dig5c", 32'(u_if.digit_out), 32'd5);
      chk("t3_valid_stall", 32'(u_if.digit_valid), 32'd1);
      u_if.digit_ready = 1'b1;
      hold(S4, 4);
      chk("t3_n", 32'(acc_q.size()), 32'd2);
      chk("t3_first", 32'(acc_at(0)), 32'h05);
      chk("t3_second", 32'(acc_at(1)), 32'h04);
      chk("t3_drained", 32'(u_if.digit_valid), 32'd0);

      // invalid pattern and error counter
      acc_q.delete();
      hold(SBAD, 8);
      chk("t4_n", 32'(acc_q.size()), 32'd1);
      chk("t4_val", 32'(acc_at(0)), 32'h1F);
      chk("t4_err1", 32'(err_count), 32'(ERR_ONE));
      acc_q.delete();
      for (int i = 0; i < 300; i++) begin
         hold(SBLK, 6);
         hold(SBAD, 6);
      end
      hold(SBAD, 2);
      chk("t4_n300", 32'(acc_q.size()), 32'd300);
      chk("t4_err_sat", 32'(err_count), 32'(ERR_SAT));

      // blank between repeats re-emits; 1-cycle glitch does not
      hold(SBLK, 8);
      acc_q.delete();
      hold(S8, 8);
      hold(SBLK, 6);
      hold(S8, 8);
      chk("t5_blank_n", 32'(acc_q.size()), 32'd2);
      chk("t5_blank_a", 32'(acc_at(0)), 32'h08);
      chk("t5_blank_b", 32'(acc_at(1)), 32'h08);
      hold(SGL, 1);
      hold(S8, 10);
      chk("t5_glitch_n", 32'(acc_q.size()), 32'd2);

      // reset drops a pending slot; same pattern re-emits afterwards
      u_if.digit_ready = 1'b0;
      hold(S9, 8);
      chk("t6_pend_valid", 32'(u_if.digit_valid), 32'd1);
      chk("t6_pend_dig", 32'(u_if.digit_out), 32'd9);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("t6_rst_valid", 32'(u_if.digit_valid), 32'd0);
      chk("t6_rst_dig", 32'(u_if.digit_out), 32'd0);
      chk("t6_rst_err", 32'(err_count), 32'd0);
      hold(S9, 8);
      chk("t6_re_valid", 32'(u_if.digit_valid), 32'd1);
      chk("t6_re_dig", 32'(u_if.digit_out), 32'd9);
      chk("t6_re_inv", 32'(u_if.invalid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receiving end of the 7-segment display interface: samples a 7-bit segment pattern from the pins, qualifies it as stable, and decodes it back to a BCD digit (segments -> digit; the inverse of the seg7 decoder).
- Pushes each newly settled digit out through a one-deep valid/ready slot.
- Sits behind the top-level ui_in pins as the input front end for the FIR datapath; also serves as loop-back checker for the display path.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a pattern counts as settled; legal range 2..255.
- CNT_W, 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous reset, active low.
- ena, input, 1: block enable; low freezes detection.
- seg_in, input, 7: segment pattern {g,f,e,d,c,b,a}, active high; bit0 = a.
- digit_out, output, 4: decoded digit 0..9, or 4'hF for an invalid pattern.
- invalid, output, 1: qualifies digit_out; high when the emitted pattern was not a legal digit.
- digit_valid, output, 1: output slot holds data.
- digit_ready, input, 1: consumer accepts the slot when digit_valid && digit_ready.
- err_count, output, 8: invalid-pattern counter (see Optional Feature).

Behaviour:
- Reset, applied at a rising edge while rst_n = 0:
  - Outputs: digit_out = 0, invalid = 0, digit_valid = 0, err_count = 0.
  - Internal state: sample register = 0, counter = 0, last_emitted = blank (7'b0), state = IDLE.
  - Reset mid-transfer drops any pending slot without handshake.
- Legal patterns, matching the seg7 table:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Any other non-zero pattern is invalid. 7'b0 is blank.
- Input register: seg_in is registered every cycle when ena = 1. All detection uses the registered value (samp) and its predecessor (prev).
- Counter: if samp == prev, the counter increments and saturates at STABLE_CYCLES-1. Otherwise it clears to 0.
- FSM states:
  - IDLE: ena = 0. Counter held at 0, no emissions, slot contents and handshake still honoured. Any state goes to IDLE when ena = 0. IDLE goes to SETTLE when ena = 1.
  - SETTLE: counter < STABLE_CYCLES-1. Goes to LOCKED when the counter reaches STABLE_CYCLES-1.
  - LOCKED: pattern settled. Any sample change returns to SETTLE with counter 0.
- Emit condition, evaluated in LOCKED each cycle: samp != last_emitted, samp != blank, and slot free (digit_valid == 0, or digit_valid && digit_ready this cycle).
  - On emit, at the next edge: digit_out/invalid are loaded from the decode, digit_valid = 1, last_emitted = samp.
- Blank settled in LOCKED: last_emitted = blank, nothing is emitted. Re-showing the same digit after a blank therefore re-emits it.
- Latency: a new pattern first present on seg_in before edge 1 (all later samples identical, slot free) raises digit_valid after edge STABLE_CYCLES+2.
- Slot rules:
  - digit_out/invalid are stable while digit_valid && !digit_ready.
  - Accept without re-emit: the slot clears next edge.
  - Accept and emit in the same cycle: the slot reloads, and digit_valid stays high.
- Backpressure: while the slot is full, a settled pattern waits in LOCKED. Intermediate patterns that settle and change again during the stall are lost; only the pattern settled when the slot frees is emitted.
- Glitch: a 1-cycle deviation restarts the count. The original pattern, once re-settled, equals last_emitted and is not re-emitted.

Optional Feature:
- Macro: SEG7_READER_ERRCNT_EN.
- Defined: err_count increments by 1 on each emit with invalid = 1 and saturates at 255. It is cleared only by reset.
- Undefined: err_count is tied to 8'h00 and no counter logic is built. The port is present in both builds.

Test Plan (STABLE_CYCLES = 4, digit_ready = 1 unless stated):
- Reset, then seg_in = 1001111 held 10 cycles -> one digit_valid pulse, digit_out = 3, invalid = 0, asserted after edge 6 from first sample.
- seg_in = 0000110 for 3 cycles, then 1011011 held -> no emit for 1; single emit digit_out = 2.
- digit_ready = 0; emit 5 (1101101); then apply 7 (0000111) settled, then 4 (1100110) settled -> slot holds 5 until ready = 1. Next emit is 4 only, 7 is never emitted.
- seg_in = 1010101 held -> digit_out = 4'hF, invalid = 1. With the macro, err_count = 1; 300 such alternating invalid/blank events -> err_count = 255.
- Digit 8, then blank 0000000 for 6 cycles, then 8 again -> two emits of 8. Digit 8 with a 1-cycle glitch to 1111110 -> one emit only.
- Emit 9 pending with ready = 0, assert rst_n = 0 one cycle -> digit_valid = 0, digit_out = 0 next cycle. Same pattern held after reset re-emits 9.
